alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_sticky_flags.sv | 46 ++++
 rtl/alu_result_fifo.sv | 113 +++++++++++
 tb/tb_alu_result_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU result FIFO and its sticky-flag logic.
//   - opcode encodings (AND..XOR, 3'b000..3'b111)
//   - flag bit positions inside a packed {overflow, carry, zero} field
//   - the layout and width of one stored FIFO entry
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_NOT = 3'b110,
    OP_XOR = 3'b111
  } opcode_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;

  localparam int ENTRY_W = 14;

  // One FIFO entry: 3 + 3 + 8 = ENTRY_W bits.
  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] flags;
    logic [7:0] result;
  } entry_t;

  // Overflow is only meaningful for the arithmetic opcodes.
  function automatic logic is_add_sub(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_sticky_flags.sv
// alu_sticky_flags: accumulates exception flags from accepted ALU results.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push                  an entry is being accepted this cycle
//   opcode                opcode of the accepted entry
//   carry, overflow       flags of the accepted entry
//   clr                   clear both sticky flags at the next edge
//   sticky_carry          set by an ADD with carry
//   sticky_overflow       set by an ADD or SUB with overflow
module alu_sticky_flags
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [2:0] opcode,
  input  logic       carry,
  input  logic       overflow,
  input  logic       clr,
  output logic       sticky_carry,
  output logic       sticky_overflow
);

  logic carry_reg;
  logic overflow_reg;
  logic set_carry;
  logic set_overflow;

  assign set_carry    = push && (opcode == OP_ADD) && carry;
  assign set_overflow = push && is_add_sub(opcode) && overflow;

  // A qualifying push in the same cycle as clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      carry_reg    <= set_carry    | (carry_reg    & ~clr);
      overflow_reg <= set_overflow | (overflow_reg & ~clr);
    end
  end

  assign sticky_carry    = carry_reg;
  assign sticky_overflow = overflow_reg;

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO of ALU results with sticky exception flags.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready                producer handshake
//   in_result, in_opcode             result byte and the opcode that made it
//   in_zero, in_carry, in_overflow   flags for in_result
//   out_valid/out_ready              consumer handshake
//   out_result, out_opcode           head entry
//   out_flags                        head flags {overflow, carry, zero}
//   count                            occupancy 0..DEPTH
//   clr_sticky                       clear sticky flags
//   sticky_carry, sticky_overflow    accumulated exception flags
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_result,
  input  logic [2:0]               in_opcode,
  input  logic                     in_zero,
  input  logic                     in_carry,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_result,
  output logic [2:0]               out_opcode,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic                     sticky_carry,
  output logic                     sticky_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  entry_t          wr_entry;
  entry_t          head;
  logic            push;
  logic            pop;

  // Handshake depends on registered occupancy only, so a full FIFO cannot
  // accept in the same cycle it is popped.
  assign in_ready  = (count_reg < CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_entry               = '0;
    wr_entry.result        = in_result;
    wr_entry.opcode        = in_opcode;
    wr_entry.flags[FLAG_Z] = in_zero;
    wr_entry.flags[FLAG_C] = in_carry;
    wr_entry.flags[FLAG_V] = in_overflow;
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Show-ahead: the head entry is visible while it waits for out_ready.
  assign head       = mem[rd_ptr_reg];
  assign out_result = head.result;
  assign out_opcode = head.opcode;
  assign out_flags  = head.flags;
  assign count      = count_reg;

  alu_sticky_flags u_sticky (
    .clk             (clk),
    .rst             (rst),
    .push            (push),
    .opcode          (in_opcode),
    .carry           (in_carry),
    .overflow        (in_overflow),
    .clr             (clr_sticky),
    .sticky_carry    (sticky_carry),
    .sticky_overflow (sticky_overflow)
  );

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [2:0] in_opcode;
  logic       in_zero;
  logic       in_carry;
  logic       in_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_opcode;
  logic [2:0] out_flags;
  logic [2:0] count;
  logic       clr_sticky;
  logic       sticky_carry;
  logic       sticky_overflow;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_result       (in_result),
    .in_opcode       (in_opcode),
    .in_zero         (in_zero),
    .in_carry        (in_carry),
    .in_overflow     (in_overflow),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_opcode      (out_opcode),
    .out_flags       (out_flags),
    .count           (count),
    .clr_sticky      (clr_sticky),
    .sticky_carry    (sticky_carry),
    .sticky_overflow (sticky_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {opcode, flags, result} plus two bits.
  logic [13:0] q[$];
  logic        m_sc;
  logic        m_sv;
  logic        m_push;
  logic        m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_sc = 1'b0;
      m_sv = 1'b0;
    end else begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = out_ready && (q.size() != 0);
      m_sc = (m_push && in_opcode == 3'b010 && in_carry) || (m_sc && !clr_sticky);
      m_sv = (m_push && (in_opcode == 3'b010 || in_opcode == 3'b011) && in_overflow)
             || (m_sv && !clr_sticky);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({in_opcode, in_overflow, in_carry, in_zero, in_result});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("sticky_carry", 32'(sticky_carry), 32'(m_sc));
      chk("sticky_overflow", 32'(sticky_overflow), 32'(m_sv));
      if (q.size() != 0) begin
        chk("out_result", 32'(out_result), 32'(q[0][7:0]));
        chk("out_flags", 32'(out_flags), 32'(q[0][10:8]));
        chk("out_opcode", 32'(out_opcode), 32'(q[0][13:11]));
      end
    end
  end

  task automatic idle();
    in_valid    = 1'b0;
    in_result   = 8'h00;
    in_opcode   = 3'b000;
    in_zero     = 1'b0;
    in_carry    = 1'b0;
    in_overflow = 1'b0;
    out_ready   = 1'b0;
    clr_sticky  = 1'b0;
  endtask

  // Apply one cycle of inputs, let the edge happen, return 2 units after it.
  task automatic drive(input logic v, input logic [7:0] res, input logic [2:0] op,
                       input logic z, input logic c, input logic ovf,
                       input logic rdy, input logic clr);
    in_valid    = v;
    in_result   = res;
    in_opcode   = op;
    in_zero     = z;
    in_carry    = c;
    in_overflow = ovf;
    out_ready   = rdy;
    clr_sticky  = clr;
    @(posedge clk);
    #2;
    $display("txn: in_valid=%0b data=%02h op=%0d zcv=%0b%0b%0b out_ready=%0b clr=%0b -> count=%0d head=%02h sc=%0b sv=%0b",
             v, res, op, z, c, ovf, rdy, clr, count, out_result, sticky_carry, sticky_overflow);
    idle();
  endtask

  task automatic pop1();
    drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_sticky_c", 32'(sticky_carry), 0);
    chk("rst_sticky_v", 32'(sticky_overflow), 0);

    // Single push, visible the next cycle.
    drive(1'b1, 8'h0F, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_valid", 32'(out_valid), 1);
    chk("first_result", 32'(out_result), 32'h0F);
    chk("first_opcode", 32'(out_opcode), 2);
    chk("first_flags", 32'(out_flags), 0);
    chk("first_count", 32'(count), 1);
    chk("first_sticky_c", 32'(sticky_carry), 0);
    pop1();
    chk("drain_count", 32'(count), 0);
    pop1();  // pop on empty is ignored
    chk("empty_pop_count", 32'(count), 0);

    // Fill, refuse fifth push.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 3'b000, i[0], i[1], i[2], 1'b0, 1'b0);
    end
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    drive(1'b1, 8'h05, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("refused_count", 32'(count), 4);
    chk("head_01", 32'(out_result), 32'h01);
    chk("head_01_flags", 32'(out_flags), 3'b001);

    // Pop and push together while full: only the pop happens.
    drive(1'b1, 8'h05, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_in_ready", 32'(in_ready), 1);
    drive(1'b1, 8'h05, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("repush_count", 32'(count), 4);
    for (int k = 2; k <= 5; k++) begin
      chk("order_head", 32'(out_result), 32'(k));
      pop1();
    end
    chk("order_empty", 32'(count), 0);

    // Sticky carry.
    drive(1'b1, 8'h80, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sc_add", 32'(sticky_carry), 1);
    drive(1'b1, 8'h81, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sc_and_keep", 32'(sticky_carry), 1);
    drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sc_clr", 32'(sticky_carry), 0);
    drive(1'b1, 8'h82, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sc_and_ignored", 32'(sticky_carry), 0);
    drive(1'b1, 8'h83, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sc_set_wins", 32'(sticky_carry), 1);
    drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sc_clr_again", 32'(sticky_carry), 0);
    repeat (4) pop1();
    chk("sc_drained", 32'(count), 0);

    // Sticky overflow.
    drive(1'b1, 8'h11, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sv_xor_ignored", 32'(sticky_overflow), 0);
    drive(1'b1, 8'h22, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sv_sub", 32'(sticky_overflow), 1);
    pop1();
    pop1();
    chk("sv_persist", 32'(sticky_overflow), 1);
    chk("sv_persist_empty", 32'(out_valid), 0);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h30 + i), 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_sc", 32'(sticky_carry), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_sc", 32'(sticky_carry), 0);
    chk("mid_rst_sv", 32'(sticky_overflow), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    repeat (6) pop1();
    chk("final_count", 32'(count), 32'(q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
